// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus shared between the pipeline datapath and the
// hazard controller. The datapath (master) supplies the stage register
// fields; the controller (slave) returns stall, flush and forward selects.
interface pipeline_hazard_ctrl_if;
  logic [3:0]  rf1_D;
  logic [3:0]  rf2_D;
  logic [3:0]  rf1_pipeDout;
  logic [3:0]  rf2_pipeDout;
  logic [3:0]  rdPipeD_Out;
  logic [1:0]  wEnRegPipeD_Out;
  logic        memoryMuxSelPipeD_Out;
  logic [3:0]  rdPipeE_Out;
  logic [1:0]  wEnRegPipeE_Out;
  logic [3:0]  rdPipeM_Out;
  logic [1:0]  wEnRegPipeM_Out;
  logic        jmpTaken_E;
  logic        memBusy;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        flushD;
  logic        flushE;
  logic [1:0]  fwdA_sel;
  logic [1:0]  fwdB_sel;
  logic [15:0] stallCount;

  modport master (
    output rf1_D, rf2_D, rf1_pipeDout, rf2_pipeDout,
    output rdPipeD_Out, wEnRegPipeD_Out, memoryMuxSelPipeD_Out,
    output rdPipeE_Out, wEnRegPipeE_Out, rdPipeM_Out, wEnRegPipeM_Out,
    output jmpTaken_E, memBusy,
    input  stallF, stallD, stallE, flushD, flushE,
    input  fwdA_sel, fwdB_sel, stallCount
  );

  modport slave (
    input  rf1_D, rf2_D, rf1_pipeDout, rf2_pipeDout,
    input  rdPipeD_Out, wEnRegPipeD_Out, memoryMuxSelPipeD_Out,
    input  rdPipeE_Out, wEnRegPipeE_Out, rdPipeM_Out, wEnRegPipeM_Out,
    input  jmpTaken_E, memBusy,
    output stallF, stallD, stallE, flushD, flushE,
    output fwdA_sel, fwdB_sel, stallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, jump flushes, load-use
// stalls, operand forwarding and a saturating stall-cycle counter.
// Optional feature macro HAZARD_FWD_EN: when defined, operands are
// forwarded and only a load-use case stalls; when undefined, forwarding is
// off and any in-flight write to a decode source register stalls.
module pipeline_hazard_ctrl (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t      state;
  state_t      next_state;
  logic        ex_match;
  logic        mem_match;
  logic        wb_match;
  logic        load_use;
  logic [1:0]  fwd_a_raw;
  logic [1:0]  fwd_b_raw;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        flush_d;
  logic        flush_e;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;

  // A stage only counts as a writer when it writes a register other than r0.
  assign ex_match  = (hz.wEnRegPipeD_Out != 2'b00) && (hz.rdPipeD_Out != 4'd0);
  assign mem_match = (hz.wEnRegPipeE_Out != 2'b00) && (hz.rdPipeE_Out != 4'd0);
  assign wb_match  = (hz.wEnRegPipeM_Out != 2'b00) && (hz.rdPipeM_Out != 4'd0);

`ifdef HAZARD_FWD_EN
  // Only a load in execute feeding decode needs a bubble; the rest forwards.
  assign load_use = hz.memoryMuxSelPipeD_Out && ex_match &&
                    ((hz.rdPipeD_Out == hz.rf1_D) || (hz.rdPipeD_Out == hz.rf2_D));

  // Forward select per operand, the younger memory-stage result winning.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (mem_match && (hz.rdPipeE_Out == hz.rf1_pipeDout))
      fwd_a_raw = 2'b01;
    else if (wb_match && (hz.rdPipeM_Out == hz.rf1_pipeDout))
      fwd_a_raw = 2'b10;
    if (mem_match && (hz.rdPipeE_Out == hz.rf2_pipeDout))
      fwd_b_raw = 2'b01;
    else if (wb_match && (hz.rdPipeM_Out == hz.rf2_pipeDout))
      fwd_b_raw = 2'b10;
  end
`else
  logic unused_fwd_inputs;

  // Without forwarding, any pending write to a decode source is a hazard.
  assign load_use =
    (ex_match  && ((hz.rdPipeD_Out == hz.rf1_D) || (hz.rdPipeD_Out == hz.rf2_D))) ||
    (mem_match && ((hz.rdPipeE_Out == hz.rf1_D) || (hz.rdPipeE_Out == hz.rf2_D))) ||
    (wb_match  && ((hz.rdPipeM_Out == hz.rf1_D) || (hz.rdPipeM_Out == hz.rf2_D)));

  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
  assign unused_fwd_inputs = ^{hz.rf1_pipeDout, hz.rf2_pipeDout, hz.memoryMuxSelPipeD_Out};
`endif

  // State register, returned to RUN by a clocked low reset.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= RUN;
    else
      state <= next_state;
  end

  // Stay in MEM_WAIT exactly as long as the data memory reports busy.
  always_comb begin
    next_state = state;
    case (state)
      RUN:      next_state = hz.memBusy ? MEM_WAIT : RUN;
      MEM_WAIT: next_state = hz.memBusy ? MEM_WAIT : RUN;
      default:  next_state = RUN;
    endcase
  end

  // Stall/flush/forward decode; everything is held at zero during reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (rst) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      case (state)
        MEM_WAIT: begin
          if (hz.memBusy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
          end else if (hz.jmpTaken_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        default: begin
          if (hz.memBusy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
          end else if (hz.jmpTaken_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      endcase
    end
  end

  // Count cycles in which fetch is held, sticking at the top value.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_count <= 16'd0;
    else if (stall_f && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

  assign hz.stallF     = stall_f;
  assign hz.stallD     = stall_d;
  assign hz.stallE     = stall_e;
  assign hz.flushD     = flush_d;
  assign hz.flushE     = flush_e;
  assign hz.fwdA_sel   = fwd_a;
  assign hz.fwdB_sel   = fwd_b;
  assign hz.stallCount = stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   model_count = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic writes(input logic [3:0] rd, input logic [1:0] wen);
    return (wen != 2'b00) && (rd != 4'd0);
  endfunction

  function automatic logic [1:0] fwd_for(input logic [3:0] src);
`ifdef HAZARD_FWD_EN
    if (writes(hz.rdPipeE_Out, hz.wEnRegPipeE_Out) && hz.rdPipeE_Out == src) return 2'b01;
    if (writes(hz.rdPipeM_Out, hz.wEnRegPipeM_Out) && hz.rdPipeM_Out == src) return 2'b10;
`endif
    return 2'b00;
  endfunction

  // Expected {stallF,stallD,stallE,flushD,flushE,fwdA,fwdB} from current inputs.
  function automatic logic [8:0] model_outputs();
    logic [3:0] rds [3];
    logic [1:0] wens[3];
    logic       hazard;
    rds  = '{hz.rdPipeD_Out, hz.rdPipeE_Out, hz.rdPipeM_Out};
    wens = '{hz.wEnRegPipeD_Out, hz.wEnRegPipeE_Out, hz.wEnRegPipeM_Out};
    hazard = 1'b0;
`ifdef HAZARD_FWD_EN
    if (hz.memoryMuxSelPipeD_Out && writes(rds[0], wens[0]) &&
        (rds[0] == hz.rf1_D || rds[0] == hz.rf2_D))
      hazard = 1'b1;
`else
    for (int k = 0; k < 3; k++)
      if (writes(rds[k], wens[k]) && (rds[k] == hz.rf1_D || rds[k] == hz.rf2_D))
        hazard = 1'b1;
`endif
    if (!rst)          return 9'b0;
    if (hz.memBusy)    return {5'b11100, fwd_for(hz.rf1_pipeDout), fwd_for(hz.rf2_pipeDout)};
    if (hz.jmpTaken_E) return {5'b00011, fwd_for(hz.rf1_pipeDout), fwd_for(hz.rf2_pipeDout)};
    if (hazard)        return {5'b11001, fwd_for(hz.rf1_pipeDout), fwd_for(hz.rf2_pipeDout)};
    return {5'b00000, fwd_for(hz.rf1_pipeDout), fwd_for(hz.rf2_pipeDout)};
  endfunction

  function automatic logic [8:0] dut_bundle();
    return {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.fwdA_sel, hz.fwdB_sel};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out"}, 32'(dut_bundle()), 32'(model_outputs()));
    checkValue({tag, ".cnt"}, 32'(hz.stallCount), 32'(model_count));
  endtask

  task automatic clearInputs();
    rst = 1'b1;
    hz.rf1_D = 4'd0; hz.rf2_D = 4'd0; hz.rf1_pipeDout = 4'd0; hz.rf2_pipeDout = 4'd0;
    hz.rdPipeD_Out = 4'd0; hz.wEnRegPipeD_Out = 2'b00; hz.memoryMuxSelPipeD_Out = 1'b0;
    hz.rdPipeE_Out = 4'd0; hz.wEnRegPipeE_Out = 2'b00;
    hz.rdPipeM_Out = 4'd0; hz.wEnRegPipeM_Out = 2'b00;
    hz.jmpTaken_E = 1'b0; hz.memBusy = 1'b0;
  endtask

  task automatic applyStimulus();
    rst = ($urandom_range(0, 29) != 0);
    hz.rf1_D = 4'($urandom_range(0, 3));        hz.rf2_D = 4'($urandom_range(0, 3));
    hz.rf1_pipeDout = 4'($urandom_range(0, 3)); hz.rf2_pipeDout = 4'($urandom_range(0, 3));
    hz.rdPipeD_Out = 4'($urandom_range(0, 3));  hz.wEnRegPipeD_Out = 2'($urandom_range(0, 3));
    hz.memoryMuxSelPipeD_Out = 1'($urandom_range(0, 1));
    hz.rdPipeE_Out = 4'($urandom_range(0, 3));  hz.wEnRegPipeE_Out = 2'($urandom_range(0, 3));
    hz.rdPipeM_Out = 4'($urandom_range(0, 3));  hz.wEnRegPipeM_Out = 2'($urandom_range(0, 3));
    hz.jmpTaken_E = ($urandom_range(0, 7) == 0);
    hz.memBusy = ($urandom_range(0, 5) == 0);
  endtask

  // Advance one clock: model counter follows the edge, inputs change at negedge.
  task automatic tick();
    logic [8:0] exp;
    @(posedge clk);
    exp = model_outputs();
    if (!rst) model_count = 0;
    else if (exp[8] && model_count < 16'hFFFF) model_count++;
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1 checkOutput(tag);
    tick();
  endtask

  initial begin
    clearInputs();
    @(negedge clk);

    // Reset overrides busy and jump requests.
    rst = 1'b0; hz.memBusy = 1'b1; hz.jmpTaken_E = 1'b1;
    step("reset");
    step("reset2");
    checkValue("reset.cnt", 32'(hz.stallCount), 32'd0);

    // Load to r3 with decode reading r3: single bubble.
    clearInputs();
    hz.rdPipeD_Out = 4'd3; hz.wEnRegPipeD_Out = 2'b01; hz.memoryMuxSelPipeD_Out = 1'b1; hz.rf1_D = 4'd3;
    #1 checkValue("loaduse.ctl", 32'(dut_bundle()), 32'({5'b11001, 4'b0000}));
    step("loaduse");
    clearInputs();
    step("loaduse.after");
    checkValue("loaduse.cnt", 32'(hz.stallCount), 32'd1);

    // Forwarding priority between memory and writeback stages.
    clearInputs();
    hz.rdPipeE_Out = 4'd5; hz.wEnRegPipeE_Out = 2'b01;
    hz.rdPipeM_Out = 4'd5; hz.wEnRegPipeM_Out = 2'b10; hz.rf2_pipeDout = 4'd5;
    step("fwd.mem");
    hz.wEnRegPipeE_Out = 2'b00;
    step("fwd.wb");
`ifdef HAZARD_FWD_EN
    checkValue("fwd.wb.sel", 32'(hz.fwdB_sel), 32'd2);
`else
    checkValue("fwd.wb.sel", 32'(hz.fwdB_sel), 32'd0);
`endif

    // Memory busy for 4 cycles swallows a pending jump.
    clearInputs();
    rst = 1'b0;
    step("busy.reset");
    rst = 1'b1; hz.memBusy = 1'b1; hz.jmpTaken_E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 checkValue("busy.hold", 32'(dut_bundle()), 32'({5'b11100, 4'b0000}));
      step("busy");
    end
    hz.memBusy = 1'b0;
    #1 checkValue("busy.jump", 32'(dut_bundle()), 32'({5'b00011, 4'b0000}));
    checkValue("busy.cnt", 32'(hz.stallCount), 32'd4);
    step("busy.release");

    // Register 0 never causes a hazard or forward.
    clearInputs();
    hz.rdPipeD_Out = 4'd0; hz.wEnRegPipeD_Out = 2'b11; hz.memoryMuxSelPipeD_Out = 1'b1;
    hz.rdPipeE_Out = 4'd0; hz.wEnRegPipeE_Out = 2'b01;
    #1 checkValue("r0.ctl", 32'(dut_bundle()), 32'd0);
    step("r0");

    // Non-load write to r7 in memory stage read by decode.
    clearInputs();
    hz.rdPipeE_Out = 4'd7; hz.wEnRegPipeE_Out = 2'b01; hz.rf2_D = 4'd7;
    step("r7");

    // A low pulse between edges must not clear the counter.
    clearInputs();
    hz.memBusy = 1'b1;
    step("pulse.pre");
    rst = 1'b0;
    #1 checkOutput("pulse.low");
    #2 rst = 1'b1;
    step("pulse.post");

    // Reset in the middle of a memory wait.
    hz.memBusy = 1'b1;
    step("midwait");
    rst = 1'b0;
    step("midwait.rst");
    checkValue("midwait.cnt", 32'(hz.stallCount), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      step("rand");
    end

    // Saturation of the stall counter.
    clearInputs();
    rst = 1'b0;
    tick();
    rst = 1'b1; hz.memBusy = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    step("sat");
    checkValue("sat.cnt", 32'(hz.stallCount), 32'hFFFF);
    rst = 1'b0;
    step("sat.rst");
    checkValue("sat.rst.cnt", 32'(hz.stallCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
